ifid_skid_reg: RTL and testbench
================================

Name: ifid_skid_reg

Overview:
Parametrised IF/ID pipeline register with a valid/ready handshake and a 2-entry skid buffer. It carries PC and fetched instruction from the fetch stage to decode, and supports back-pressure (decode stall) and flush (branch/jump redirect). Because the buffer absorbs one beat, if_ready is driven from a register and does not combinationally depend on id_ready.

Parameters:
XLEN, 32, width of PC path
ILEN, 32, width of instruction path
RESET_PC, 0, value driven on id_pc (and skid PC) at reset
RESET_INSTR, 0, value driven on id_instr (and skid instr) at reset

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset, asynchronous, active-high
if_valid  input  1  fetch beat valid
if_ready  output  1  buffer can accept a beat; registered
if_pc  input  XLEN  PC of fetched instruction
if_instr  input  ILEN  fetched instruction word
id_valid  output  1  decode-side beat valid
id_ready  input  1  decode accepts beat this cycle
id_pc  output  XLEN  PC presented to decode
id_instr  output  ILEN  instruction presented to decode
flush  input  1  kill all buffered beats (redirect)
occupancy  output  2  number of buffered beats, 0..2

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Storage: main slot M (drives id_*) and skid slot S; each holds {valid, pc, instr}.
- On reset: M.valid=0, S.valid=0, id_valid=0, id_pc=RESET_PC, id_instr=RESET_INSTR, if_ready=1, occupancy=0.
- Handshakes: accept = if_valid & if_ready; consume = id_valid & id_ready. id_valid = M.valid; if_ready = ~S.valid, taken from the register state.
- States, encoded by occupancy:
  - EMPTY (0): M and S both invalid.
  - ONE (1): M valid, S invalid.
  - FULL (2): M and S both valid.
- Transitions when flush=0:
  - EMPTY + accept -> ONE. M loads the incoming beat; it is visible on id_* the next cycle (1-cycle latency).
  - ONE + accept + consume -> ONE. M loads the incoming beat.
  - ONE + consume only -> EMPTY.
  - ONE + accept only -> FULL. S loads the incoming beat.
  - ONE + neither -> hold.
  - FULL + consume -> ONE. M <= S, and S is invalidated. No accept is possible in FULL because if_ready=0.
  - FULL + no consume -> hold.
- Flush:
  - flush=1 at a clock edge sets M.valid=0 and S.valid=0, giving EMPTY and if_ready=1 next cycle.
  - Flush has priority over accept and consume. An incoming beat in the same cycle completes its handshake on the upstream side but is discarded.
  - id_pc and id_instr hold their last values after a flush; only the valid bits clear.
- Ordering: beats leave strictly in arrival order; no beat is ever dropped or duplicated unless flushed.
- While id_valid=1 and id_ready=0, id_pc and id_instr are stable.
- Reset mid-operation: all buffered beats are discarded immediately (async) and the outputs take their reset values.
- Widths: occupancy = M.valid + S.valid. No arithmetic on PC or instr; data is passed bit-exact.

Optional Feature:
Macro IFID_NOP_INJECT_EN.
- Defined: whenever id_valid=0 (reset, empty, or after flush), id_instr is forced to the canonical NOP {ILEN{...}} = 32'h00000013 (addi x0,x0,0), zero-extended or truncated to ILEN. id_pc is unaffected.
- Undefined: id_instr shows the M register contents regardless of id_valid.

Test Plan:
- Reset: assert rst mid-stream with occupancy=2 -> same cycle id_valid=0, if_ready=1, occupancy=0, id_pc=0, id_instr=0 (32'h00000013 with IFID_NOP_INJECT_EN).
- Streaming: id_ready=1, push pc 0x0,0x4,0x8 with instrs 0xA,0xB,0xC on consecutive cycles -> each appears on id_* one cycle later in order; occupancy stays 1 and if_ready stays 1.
- Back-pressure: id_ready=0, push 0x100/0x104 -> occupancy=2, if_ready=0, and 0x108 held upstream. Then id_ready=1 -> outputs 0x100, 0x104, 0x108 in order with no loss.
- Flush priority: occupancy=2 with flush=1, if_valid=1, id_ready=1 in the same cycle -> next cycle occupancy=0, id_valid=0, and the incoming beat is not delivered.
- Stability: with occupancy=1, hold id_ready=0 for 5 cycles -> id_pc and id_instr unchanged and id_valid=1 throughout.
- Flush-then-fetch: flush followed next cycle by a push of pc 0x200 -> id_pc=0x200 and id_valid=1 one cycle later.

Source files
------------

// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline register with a registered-ready 2-entry skid buffer and flush.
// Optional macro IFID_NOP_INJECT_EN forces id_instr to the canonical NOP while id_valid=0.
module ifid_skid_reg #(
    parameter int              XLEN        = 32,
    parameter int              ILEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter logic [ILEN-1:0] RESET_INSTR = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_pc,
    input  logic [ILEN-1:0] if_instr,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [ILEN-1:0] id_instr,
    input  logic            flush,
    output logic [1:0]      occupancy
);

    // The state value is the number of buffered beats, so it doubles as occupancy.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [XLEN-1:0] m_pc, s_pc;
    logic [ILEN-1:0] m_instr, s_instr;
    logic            accept, consume;
    logic            m_load_in, m_load_skid, s_load;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) state_nxt = ONE;
                ONE: begin
                    if (accept && !consume)      state_nxt = FULL;
                    else if (!accept && consume) state_nxt = EMPTY;
                end
                FULL:    if (consume) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Handshake outputs depend only on the state register, never on id_ready.
    always_comb begin
        if_ready  = (state != FULL);
        id_valid  = (state != EMPTY);
        occupancy = state;
    end

    assign accept      = if_valid & if_ready;
    assign consume     = id_valid & id_ready;
    assign m_load_in   = accept & ((state == EMPTY) | ((state == ONE) & consume));
    assign m_load_skid = (state == FULL) & consume;
    assign s_load      = accept & (state == ONE) & ~consume;

    // NOTE: payload registers are reset because id_pc/id_instr have defined reset values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc    <= RESET_PC;
            m_instr <= RESET_INSTR;
            s_pc    <= RESET_PC;
            s_instr <= RESET_INSTR;
        end else if (!flush) begin
            // Flush clears only the valid bits; payload keeps its last value.
            if (m_load_in) begin
                m_pc    <= if_pc;
                m_instr <= if_instr;
            end else if (m_load_skid) begin
                m_pc    <= s_pc;
                m_instr <= s_instr;
            end
            if (s_load) begin
                s_pc    <= if_pc;
                s_instr <= if_instr;
            end
        end
    end

    assign id_pc = m_pc;

`ifdef IFID_NOP_INJECT_EN
    localparam logic [ILEN-1:0] NOP_INSTR = ILEN'(32'h0000_0013);
    assign id_instr = id_valid ? m_instr : NOP_INSTR;
`else
    assign id_instr = m_instr;
`endif

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Scoreboard bench for ifid_skid_reg: driver pushes accepted beats, monitor pops on consume.
module tb_ifid_skid_reg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } beat_t;

`ifdef IFID_NOP_INJECT_EN
    localparam logic [31:0] IDLE_INSTR = 32'h0000_0013;
`else
    localparam logic [31:0] IDLE_INSTR = 32'h0000_0000;
`endif

    logic        clk, rst;
    logic        if_valid, if_ready, id_valid, id_ready, flush;
    logic [31:0] if_pc, if_instr, id_pc, id_instr;
    logic [1:0]  occupancy;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_err    = 0;

    ifid_skid_reg #(.XLEN(32), .ILEN(32), .RESET_PC(32'h0), .RESET_INSTR(32'h0)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr),
        .flush(flush), .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock of stimulus; beats the DUT accepts (outside flush) enter the scoreboard.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic rdy, input logic fl);
        if_valid = v; if_pc = pc; if_instr = ins; id_ready = rdy; flush = fl;
        @(negedge clk);
        if (v && if_ready && !fl) exp_q.push_back('{pc: pc, instr: ins});
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input logic v, input logic r, input logic [1:0] occ);
        check({tag, ".id_valid"},  32'(id_valid),  32'(v));
        check({tag, ".if_ready"},  32'(if_ready),  32'(r));
        check({tag, ".occupancy"}, 32'(occupancy), 32'(occ));
    endtask

    // Monitor: every consume seen before the edge must match the oldest expected beat.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (flush) begin
            exp_q.delete();
        end else if (id_valid && id_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_beat: got pc=%h instr=%h required none", id_pc, id_instr);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("sb.id_pc", id_pc, e.pc);
                check("sb.id_instr", id_instr, e.instr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_pc = '0; if_instr = '0; id_ready = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_status("reset", 1'b0, 1'b1, 2'd0);
        check("reset.id_pc", id_pc, 32'h0);
        check("reset.id_instr", id_instr, IDLE_INSTR);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Streaming: each beat visible one cycle after it is pushed
        cycle(1'b1, 32'h0, 32'hA, 1'b1, 1'b0);
        check_status("stream0", 1'b1, 1'b1, 2'd1); check("stream0.id_pc", id_pc, 32'h0);
        cycle(1'b1, 32'h4, 32'hB, 1'b1, 1'b0);
        check_status("stream1", 1'b1, 1'b1, 2'd1); check("stream1.id_pc", id_pc, 32'h4);
        cycle(1'b1, 32'h8, 32'hC, 1'b1, 1'b0);
        check_status("stream2", 1'b1, 1'b1, 2'd1); check("stream2.id_instr", id_instr, 32'hC);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_status("stream_drain", 1'b0, 1'b1, 2'd0);

        // Back-pressure: fill both slots, hold the third beat upstream, then drain
        cycle(1'b1, 32'h100, 32'h1, 1'b0, 1'b0);
        check_status("bp0", 1'b1, 1'b1, 2'd1);
        cycle(1'b1, 32'h104, 32'h2, 1'b0, 1'b0);
        check_status("bp1", 1'b1, 1'b0, 2'd2);
        cycle(1'b1, 32'h108, 32'h3, 1'b0, 1'b0);
        check_status("bp_hold", 1'b1, 1'b0, 2'd2); check("bp_hold.id_pc", id_pc, 32'h100);
        cycle(1'b1, 32'h108, 32'h3, 1'b1, 1'b0);
        check_status("bp_pop0", 1'b1, 1'b1, 2'd1); check("bp_pop0.id_pc", id_pc, 32'h104);
        cycle(1'b1, 32'h108, 32'h3, 1'b1, 1'b0);
        check_status("bp_pop1", 1'b1, 1'b1, 2'd1); check("bp_pop1.id_pc", id_pc, 32'h108);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_status("bp_drain", 1'b0, 1'b1, 2'd0);

        // Flush priority over accept and consume while full
        cycle(1'b1, 32'h300, 32'h30, 1'b0, 1'b0);
        cycle(1'b1, 32'h304, 32'h31, 1'b0, 1'b0);
        check_status("fl_full", 1'b1, 1'b0, 2'd2);
        cycle(1'b1, 32'h308, 32'h32, 1'b1, 1'b1);
        check_status("fl_after", 1'b0, 1'b1, 2'd0);
        check("fl_after.id_pc", id_pc, 32'h300);
`ifdef IFID_NOP_INJECT_EN
        check("fl_after.id_instr", id_instr, 32'h13);
`else
        check("fl_after.id_instr", id_instr, 32'h30);
`endif
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_status("fl_idle", 1'b0, 1'b1, 2'd0);

        // Stability under a 5-cycle stall
        cycle(1'b1, 32'h400, 32'h40, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            check("stall.id_valid", 32'(id_valid), 32'h1);
            check("stall.id_pc", id_pc, 32'h400);
            check("stall.id_instr", id_instr, 32'h40);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_status("stall_drain", 1'b0, 1'b1, 2'd0);

        // Flush then fetch on the very next cycle
        cycle(1'b1, 32'h500, 32'h50, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        check_status("ff_flush", 1'b0, 1'b1, 2'd0);
        cycle(1'b1, 32'h200, 32'h20, 1'b1, 1'b0);
        check_status("ff_fetch", 1'b1, 1'b1, 2'd1); check("ff_fetch.id_pc", id_pc, 32'h200);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset with both slots occupied
        cycle(1'b1, 32'h600, 32'h60, 1'b0, 1'b0);
        cycle(1'b1, 32'h604, 32'h61, 1'b0, 1'b0);
        check_status("rst_full", 1'b1, 1'b0, 2'd2);
        if_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check_status("rst_async", 1'b0, 1'b1, 2'd0);
        check("rst_async.id_pc", id_pc, 32'h0);
        check("rst_async.id_instr", id_instr, IDLE_INSTR);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_status("rst_release", 1'b0, 1'b1, 2'd0);

        check("sb.leftover_beats", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
